// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between instruction fetch (IF) and load/store (LS).
// Define MEM_ARB_RR_EN for alternating priority; otherwise LS always beats IF.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    localparam int BE_W = DATA_W / 8;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_take;
    logic                w_pick_ls;
    logic                w_done;
    logic                r_own;
    logic                r_if_gnt;
    logic                r_ls_gnt;
    logic                r_if_rvalid;
    logic                r_ls_rvalid;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_ls_rdata;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [BE_W-1:0]     r_mem_be;
`ifdef MEM_ARB_RR_EN
    logic                r_last;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_pick_ls   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ls_req || if_req) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_XFER;
`ifdef MEM_ARB_RR_EN
                    // On a tie, hand the port to whoever did not have it last.
                    if (ls_req && if_req) w_pick_ls = (r_last == OWN_IF);
                    else                  w_pick_ls = ls_req;
`else
                    w_pick_ls = ls_req;
`endif
                end
            end
            S_XFER: begin
                if (mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_own       <= OWN_IF;
            r_if_gnt    <= 1'b0;
            r_ls_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
`ifdef MEM_ARB_RR_EN
            r_last      <= OWN_IF;
`endif
        end else begin
            r_if_gnt    <= 1'b0;
            r_ls_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            if (w_take) begin
                r_own    <= w_pick_ls;
                r_if_gnt <= ~w_pick_ls;
                r_ls_gnt <= w_pick_ls;
`ifdef MEM_ARB_RR_EN
                r_last   <= w_pick_ls;
`endif
                if (w_pick_ls) begin
                    r_mem_we    <= ls_we;
                    r_mem_addr  <= ls_addr;
                    r_mem_wdata <= ls_we ? ls_wdata : '0;
                    r_mem_be    <= ls_we ? ls_be : '1;
                end else begin
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= if_addr;
                    r_mem_wdata <= '0;
                    r_mem_be    <= '1;
                end
            end
            // Stores complete with zero data so the LSU never sees stale read data.
            if (w_done) begin
                if (r_own == OWN_LS) begin
                    r_ls_rvalid <= 1'b1;
                    r_ls_rdata  <= r_mem_we ? '0 : mem_rdata;
                end else begin
                    r_if_rvalid <= 1'b1;
                    r_if_rdata  <= mem_rdata;
                end
            end
        end
    end

    assign mem_req   = (r_state == S_XFER);
    assign busy      = (r_state == S_XFER);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign if_gnt    = r_if_gnt;
    assign ls_gnt    = r_ls_gnt;
    assign if_rvalid = r_if_rvalid;
    assign ls_rvalid = r_ls_rvalid;
    assign if_rdata  = r_if_rdata;
    assign ls_rdata  = r_ls_rdata;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequences the single shared memory port of the RV32 core between the instruction-fetch stage (IF) and the load/store path (LS) driven by the decoder's `lw_en`/`sw_en` controls. Each request is taken through a req/gnt handshake, the transfer is held on the memory bus until the memory acknowledges, and the result is returned to the owning requester as a one-cycle `rvalid` pulse. It sits between the pipeline front end / LSU and the unified memory.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte enables are `DATA_W/8` bits wide
- `clk`  in  1  core clock, all state on rising edge
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low
- `if_req`  in  1  fetch request, held until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  one-cycle grant pulse to IF
- `if_rvalid`  out  1  one-cycle pulse, `if_rdata` valid
- `if_rdata`  out  DATA_W  fetched instruction
- `ls_req`  in  1  load/store request, held until `ls_gnt`
- `ls_we`  in  1  1 = store (`sw_en`), 0 = load (`lw_en`)
- `ls_addr`  in  ADDR_W  data address
- `ls_wdata`  in  DATA_W  store data
- `ls_be`  in  DATA_W/8  store byte enables
- `ls_gnt`  out  1  one-cycle grant pulse to LS
- `ls_rvalid`  out  1  one-cycle completion pulse (loads and stores)
- `ls_rdata`  out  DATA_W  load data; 0 after a store
- `mem_req`  out  1  transfer valid to memory
- `mem_we`  out  1  write strobe
- `mem_addr`  out  ADDR_W  latched address
- `mem_wdata`  out  DATA_W  latched store data
- `mem_be`  out  DATA_W/8  latched byte enables; all ones for loads and fetches
- `mem_ack`  in  1  memory completed the transfer this cycle
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack`
- `busy`  out  1  state is XFER

## Operation
- Two states: IDLE, XFER. Owner register `own` (IF/LS).
- IDLE: if `ls_req` or `if_req` is high, select the winner, latch its address, data, byte enables and `we` into the `mem_*` registers, set `own`, and go to XFER. Otherwise stay in IDLE.
- Fixed priority (default): LS beats IF.
- XFER: `mem_req`=1 with the latched fields, stable for the whole state. Requester inputs are ignored.
- In the first XFER cycle only, pulse `if_gnt`/`ls_gnt` for `own`.
- On `mem_ack` in XFER:
  - Register `mem_rdata` into the owner's rdata register; for a store, load 0 instead.
  - Pulse the owner's `rvalid` next cycle.
  - Return to IDLE.
- `mem_ack` in IDLE is ignored.
- A request dropped before the IDLE decision edge is never granted.
- Fetches and loads always drive `mem_we`=0 and `mem_be`=all ones.
- `if_rdata`/`ls_rdata` hold their value until the owner's next completion.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state IDLE, `own`=IF.
  - All outputs 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`, both `gnt`, both `rvalid`, both `rdata`, `busy`.
- Reset mid-XFER abandons the transfer. `mem_req` falls the next cycle and no `rvalid` is issued.
- Request seen in IDLE at cycle 0 → cycle 1: XFER, `gnt`=1, `mem_req`=1.
- `mem_ack` high at cycle k≥1 → cycle k+1: IDLE, `rvalid`=1, `mem_req`=0.
- Cycle k+1 may decide the next request, so the next `mem_req` can rise at cycle k+2.
- Minimum 2 cycles per transfer. `mem_req` is never high in two back-to-back transfers without an intervening low cycle.
- `mem_ack` in the same cycle as `gnt` (k=1) is legal.
- The requester drops `req` at the edge where it samples `gnt`. The arbiter never re-grants from a `req` sampled in the grant cycle.
- Wait states are unbounded; no timeout.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - One-bit `last` register, reset to IF, updated on every grant.
  - When both request in IDLE, grant the requester not equal to `last`.
  - With only one requester, grant it.
- Undefined: fixed LS-over-IF priority and no `last` register. IF may starve while LS requests continuously.

## Test plan
- Single fetch, `if_addr`=0x100, `mem_ack` at cycle 3 with `mem_rdata`=0x00500093:
  - `if_gnt` at cycle 1.
  - `mem_req` high cycles 1–3.
  - `if_rvalid`=1 and `if_rdata`=0x00500093 at cycle 4.
- Store, `ls_addr`=0x2000, `ls_wdata`=0xDEADBEEF, `ls_be`=0xF, immediate ack:
  - `mem_we`=1 and `mem_wdata`=0xDEADBEEF at cycle 1.
  - `ls_rvalid`=1 and `ls_rdata`=0 at cycle 2.
- `if_req` and `ls_req` together, each acked immediately:
  - Default: LS granted at cycle 1, IF granted at cycle 3.
  - With `MEM_ARB_RR_EN`: LS then IF; repeating both gives LS, IF again with no starvation.
- Load with 5 wait states: `mem_addr`/`mem_be` stay constant for 6 XFER cycles while `ls_addr` changes after `gnt`; `ls_rvalid` pulses exactly once.
- Reset mid-operation: `rst_n`=0 at XFER cycle 2 → all outputs 0 next cycle, no `rvalid`, and a fresh `if_req` after release is served normally.
- Stray `mem_ack` pulsed in IDLE → no state change, no `rvalid`.
